// File: rtl/ball_pkg.sv
// ball_pkg
// Shared definitions for the ball sprite motion path.
//   ball_state_t : motion sequencer states
//   FIXED_SHIFT  : sub-pixel bits in position/velocity (pixel = pos >>> 6)
//   POS_W        : width of fixed-point position and velocity (signed)
//   EDGE_*       : bit indices inside HitEdgeCode {Left, Top, Right, Bottom}
//   abs_s        : signed absolute value at POS_W bits
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        BOUNCE = 2'd2,
        MOVE   = 2'd3
    } ball_state_t;

    localparam int FIXED_SHIFT = 6;
    localparam int POS_W       = 18;
    localparam int PIX_W       = 11;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    function automatic logic signed [POS_W-1:0] abs_s(input logic signed [POS_W-1:0] v);
        return v[POS_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/hit_edge_accumulator.sv
// hit_edge_accumulator
// OR-latch collecting per-edge hit codes over a frame. A clear and a hit in
// the same cycle leave only the new hit in the latch, so nothing is lost
// across the clear.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear_i      : drop the previously latched bits this cycle
//   acc_en_i     : allow new hits to be merged in
//   hit_i        : current pixel collides
//   code_i       : edge code qualified by hit_i
//   latch_o      : accumulated edge bits
module hit_edge_accumulator #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         acc_en_i,
    input  logic         hit_i,
    input  logic [W-1:0] code_i,
    output logic [W-1:0] latch_o
);

    logic [W-1:0] latch_q;
    logic [W-1:0] latch_d;

    always_comb begin
        latch_d = clear_i ? '0 : latch_q;
        if (acc_en_i && hit_i) begin
            latch_d = latch_d | code_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    assign latch_o = latch_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
// Per-frame motion sequencer for the ball sprite. Holds fixed-point position
// and velocity, collects edge hits during the frame, and at startOfFrame
// applies bounces (BOUNCE) then advances the position (MOVE). A ball leaving
// the left, right or bottom of the field is retired back to IDLE at spawn.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   startOfFrame    : one-cycle pulse per frame
//   launch          : start a flight from IDLE
//   collision       : ball pixel overlaps a solid object
//   HitEdgeCode     : {Left, Top, Right, Bottom}, qualified by collision
//   topLeftX/Y      : ball top-left in pixels
//   active          : ball in flight
//   hitPulse        : one cycle when a bounce is applied
//
// state  | meaning
// IDLE   | parked at spawn, zero velocity, waiting for launch
// FLIGHT | moving, accumulating hits until startOfFrame
// BOUNCE | apply latched hits to velocity, clear latch
// MOVE   | advance position, retire lost ball or clamp at ceiling
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int INIT_X                 = 320,
    parameter int INIT_Y                 = 400,
    parameter int SPEED_X                = 96,
    parameter int SPEED_Y                = -128,
    parameter int FIXED_POINT_MULTIPLIER = 64,
    parameter int X_MAX                  = 623,
    parameter int Y_MAX                  = 463
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startOfFrame,
    input  logic              launch,
    input  logic              collision,
    input  logic [3:0]        HitEdgeCode,
    output logic [PIX_W-1:0]  topLeftX,
    output logic [PIX_W-1:0]  topLeftY,
    output logic              active,
    output logic              hitPulse
);

    localparam logic signed [POS_W-1:0] SPAWN_X   = POS_W'(INIT_X * FIXED_POINT_MULTIPLIER);
    localparam logic signed [POS_W-1:0] SPAWN_Y   = POS_W'(INIT_Y * FIXED_POINT_MULTIPLIER);
    localparam logic signed [POS_W-1:0] LAUNCH_VX = POS_W'(SPEED_X);
    localparam logic signed [POS_W-1:0] LAUNCH_VY = POS_W'(SPEED_Y);
    localparam logic signed [POS_W-1:0] X_MAX_S   = POS_W'(X_MAX);
    localparam logic signed [POS_W-1:0] Y_MAX_S   = POS_W'(Y_MAX);

    ball_state_t state_q, state_d;

    logic signed [POS_W-1:0] posx_q, posx_d;
    logic signed [POS_W-1:0] posy_q, posy_d;
    logic signed [POS_W-1:0] vx_q, vx_d;
    logic signed [POS_W-1:0] vy_q, vy_d;

    logic signed [POS_W-1:0] new_x, new_y;
    logic signed [POS_W-1:0] new_px, new_py;
    logic                    lost;

    logic [3:0] hit_latch;
    logic       acc_clear;
    logic       acc_en;
    logic       hit_pulse;

    hit_edge_accumulator #(.W(4)) u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (acc_clear),
        .acc_en_i (acc_en),
        .hit_i    (collision),
        .code_i   (HitEdgeCode),
        .latch_o  (hit_latch)
    );

    assign new_x  = posx_q + vx_q;
    assign new_y  = posy_q + vy_q;
    assign new_px = new_x >>> FIXED_SHIFT;
    assign new_py = new_y >>> FIXED_SHIFT;
    // Leaving through the top is not a loss; that case is clamped instead.
    assign lost   = new_px[POS_W-1] || (new_px > X_MAX_S) || (new_py > Y_MAX_S);

    always_comb begin
        state_d   = state_q;
        posx_d    = posx_q;
        posy_d    = posy_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        acc_clear = 1'b0;
        acc_en    = 1'b1;
        hit_pulse = 1'b0;

        unique case (state_q)
            IDLE: begin
                posx_d    = SPAWN_X;
                posy_d    = SPAWN_Y;
                vx_d      = '0;
                vy_d      = '0;
                acc_clear = 1'b1;
                acc_en    = 1'b0;
                if (launch) begin
                    vx_d    = LAUNCH_VX;
                    vy_d    = LAUNCH_VY;
                    state_d = FLIGHT;
                end
            end
            FLIGHT: begin
                if (startOfFrame) begin
                    state_d = BOUNCE;
                end
            end
            BOUNCE: begin
                acc_clear = 1'b1;
                hit_pulse = |hit_latch;
                // Hits on both opposite edges mean we are wedged; just reverse.
                if (hit_latch[EDGE_LEFT] && hit_latch[EDGE_RIGHT]) begin
                    vx_d = -vx_q;
                end else if (hit_latch[EDGE_LEFT]) begin
                    vx_d = abs_s(vx_q);
                end else if (hit_latch[EDGE_RIGHT]) begin
                    vx_d = -abs_s(vx_q);
                end
                if (hit_latch[EDGE_TOP] && hit_latch[EDGE_BOTTOM]) begin
                    vy_d = -vy_q;
                end else if (hit_latch[EDGE_TOP]) begin
                    vy_d = abs_s(vy_q);
                end else if (hit_latch[EDGE_BOTTOM]) begin
                    vy_d = -abs_s(vy_q);
                end
                state_d = MOVE;
            end
            MOVE: begin
                if (lost) begin
                    posx_d  = SPAWN_X;
                    posy_d  = SPAWN_Y;
                    vx_d    = '0;
                    vy_d    = '0;
                    state_d = IDLE;
                end else begin
                    posx_d = new_x;
                    posy_d = new_y;
                    if (new_py[POS_W-1]) begin
                        posy_d = '0;
                        vy_d   = abs_s(vy_q);
                    end
                    state_d = FLIGHT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            posx_q  <= SPAWN_X;
            posy_q  <= SPAWN_Y;
            vx_q    <= '0;
            vy_q    <= '0;
        end else begin
            state_q <= state_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
        end
    end

    assign topLeftX = posx_q[FIXED_SHIFT +: PIX_W];
    assign topLeftY = posy_q[FIXED_SHIFT +: PIX_W];
    assign active   = (state_q != IDLE);
    assign hitPulse = hit_pulse;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
module tb_ball_motion_ctrl;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic        launch;
    logic        collision;
    logic [3:0]  HitEdgeCode;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        active;
    logic        hitPulse;

    int n_chk;
    int n_bad;
    int cur_x;
    int cur_y;

    ball_motion_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .launch       (launch),
        .collision    (collision),
        .HitEdgeCode  (HitEdgeCode),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .active       (active),
        .hitPulse     (hitPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int ex, input int ey, input int eact);
        chk({tag, ".x"}, int'(topLeftX), ex);
        chk({tag, ".y"}, int'(topLeftY), ey);
        chk({tag, ".active"}, int'(active), eact);
    endtask

    task automatic hit_mid(input logic [3:0] code);
        collision   = 1'b1;
        HitEdgeCode = code;
        tick();
        collision   = 1'b0;
        HitEdgeCode = 4'h0;
        tick();
    endtask

    // One frame update: pulse startOfFrame, optional collision on the
    // BOUNCE cycle, coordinates must hold through MOVE and change at t+3.
    task automatic do_frame(input string tag, input logic bcoll, input logic [3:0] bcode,
                            input int epulse, input int ex, input int ey, input int eact);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk({tag, ".pulse"}, int'(hitPulse), epulse);
        collision    = bcoll;
        HitEdgeCode  = bcode;
        tick();
        collision    = 1'b0;
        HitEdgeCode  = 4'h0;
        chk({tag, ".hold_x"}, int'(topLeftX), cur_x);
        chk({tag, ".hold_y"}, int'(topLeftY), cur_y);
        chk({tag, ".pulse_off"}, int'(hitPulse), 0);
        tick();
        chk_state(tag, ex, ey, eact);
        cur_x = ex;
        cur_y = ey;
        tick();
    endtask

    initial begin
        int fx;
        int fy;
        n_chk        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        startOfFrame = 1'b0;
        launch       = 1'b0;
        collision    = 1'b0;
        HitEdgeCode  = 4'h0;

        repeat (3) tick();
        reset = 1'b0;
        chk_state("reset", 320, 400, 0);
        chk("reset.pulse", int'(hitPulse), 0);

        // startOfFrame in IDLE does nothing
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick(); tick();
        chk_state("idle_sof", 320, 400, 0);
        chk("idle_sof.pulse", int'(hitPulse), 0);

        launch = 1'b1;
        tick();
        launch = 1'b0;
        chk_state("launch", 320, 400, 1);
        cur_x = 320;
        cur_y = 400;
        tick();

        // Free flight: X 20480+96k, Y 25600-128k (fixed point)
        do_frame("free1", 1'b0, 4'h0, 0, 321, 398, 1);
        do_frame("free2", 1'b0, 4'h0, 0, 323, 396, 1);
        do_frame("free3", 1'b0, 4'h0, 0, 324, 394, 1);
        do_frame("free4", 1'b0, 4'h0, 0, 326, 392, 1);

        // Top bounce: Vy -> +128
        hit_mid(4'h4);
        do_frame("top1", 1'b0, 4'h0, 1, 327, 394, 1);
        do_frame("top2", 1'b0, 4'h0, 0, 329, 396, 1);

        // Corner L+T, then Right merged on the BOUNCE cycle
        hit_mid(4'hC);
        do_frame("corner", 1'b1, 4'h2, 1, 330, 398, 1);
        do_frame("merged", 1'b0, 4'h0, 1, 329, 400, 1);
        do_frame("after", 1'b0, 4'h0, 0, 327, 402, 1);

        // Downward drift to the bottom: fixed X=20960-96k, Y=25728+128k
        for (int k = 1; k <= 30; k++) begin
            fx = 20960 - 96 * k;
            fy = 25728 + 128 * k;
            do_frame("drift", 1'b0, 4'h0, 0, fx / 64, fy / 64, 1);
        end
        do_frame("lost_bottom", 1'b0, 4'h0, 0, 320, 400, 0);

        launch = 1'b1;
        tick();
        launch = 1'b0;
        chk_state("relaunch", 320, 400, 1);
        tick();
        do_frame("relaunch1", 1'b0, 4'h0, 0, 321, 398, 1);

        // Reset during MOVE discards the update and the latch
        hit_mid(4'h4);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("rst_mid.pulse", int'(hitPulse), 1);
        collision   = 1'b1;
        HitEdgeCode = 4'h1;
        tick();
        collision   = 1'b0;
        HitEdgeCode = 4'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_state("rst_mid", 320, 400, 0);
        chk("rst_mid.pulse_off", int'(hitPulse), 0);
        cur_x = 320;
        cur_y = 400;

        launch = 1'b1;
        tick();
        launch = 1'b0;
        tick();
        do_frame("post_rst", 1'b0, 4'h0, 0, 321, 398, 1);

        // Climb to the ceiling: fixed X=20480+96k, Y=25600-128k
        for (int k = 2; k <= 200; k++) begin
            fx = 20480 + 96 * k;
            fy = 25600 - 128 * k;
            do_frame("climb", 1'b0, 4'h0, 0, fx / 64, fy / 64, 1);
        end
        do_frame("ceiling", 1'b0, 4'h0, 0, 621, 0, 1);
        do_frame("ceil_after", 1'b0, 4'h0, 0, 623, 2, 1);
        do_frame("lost_right", 1'b0, 4'h0, 0, 320, 400, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
